multi_desel: RTL and testbench

- Receive-side counterpart of the multi_sel product-stream transmitter.
- The transmitter sends one 8-bit operand d as a 4-beat frame of 11-bit products, in this order: d*3, d*7, d*15, d*8. The first beat is marked by input_grant.
- This block re-aligns to the frames, recovers d from the x8 beat, and cross-checks the other three beats against the recovered value.
- It emits the recovered operand with a one-cycle valid pulse, or flags a frame error. It sits directly on the transmitter's out/input_grant pair.

---
 rtl/multi_desel_pkg.sv | 27 ++
 rtl/desel_chk.sv | 39 +++
 rtl/multi_desel.sv | 103 ++++++++++
 tb/tb_multi_desel.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_desel_pkg.sv
// ============================================================================
// Module : multi_desel_pkg
// Brief  : Shared types and constants for the multi_desel frame receiver.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package multi_desel_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    S3   = 2'd3
  } state_t;

  localparam int K0       = 3;
  localparam int K1       = 7;
  localparam int K2       = 15;
  localparam int K3_SHIFT = 3;

  localparam int DEF_DW = 8;
  localparam int DEF_PW = 11;

endpackage

`default_nettype wire

// File: rtl/desel_chk.sv
// ============================================================================
// Module : desel_chk
// Brief  : Recovers d from the x8 beat and cross-checks the x3/x7/x15 beats.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module desel_chk
  import multi_desel_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int PW = DEF_PW
) (
  input  logic [PW-1:0] p0,
  input  logic [PW-1:0] p1,
  input  logic [PW-1:0] p2,
  input  logic [PW-1:0] p3,
  output logic [DW-1:0] dr,
  output logic          ok
);

  logic [PW-1:0] w_d;
  logic [PW-1:0] w_x3;
  logic [PW-1:0] w_x7;
  logic [PW-1:0] w_x15;

  // Products wrap at PW bits, matching the transmitter's truncation.
  assign w_d   = p3 >> K3_SHIFT;
  assign w_x3  = (w_d << 1) + w_d;
  assign w_x7  = (w_d << 3) - w_d;
  assign w_x15 = (w_d << 4) - w_d;

  assign dr = w_d[DW-1:0];
  assign ok = (p3[K3_SHIFT-1:0] == '0) && (p0 == w_x3) &&
              (p1 == w_x7) && (p2 == w_x15);

endmodule

`default_nettype wire

// File: rtl/multi_desel.sv
// ============================================================================
// Module : multi_desel
// Brief  : Frame receiver for the multi_sel product stream; recovers operand d.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module multi_desel
  import multi_desel_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int PW = DEF_PW,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_grant,
  input  logic [PW-1:0] in_data,
  output logic [DW-1:0] d_out,
  output logic          d_valid,
  output logic          frame_err,
  output logic [EW-1:0] err_cnt,
  output logic          busy
);

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_p0;
  logic [PW-1:0] r_p1;
  logic [PW-1:0] r_p2;
  logic          w_cap0;
  logic          w_cap1;
  logic          w_cap2;
  logic          w_eval;
  logic          w_abort;
  logic [DW-1:0] w_dr;
  logic          w_ok;
  logic          w_err;

  desel_chk #(.DW(DW), .PW(PW)) u_chk (
    .p0 (r_p0),
    .p1 (r_p1),
    .p2 (r_p2),
    .p3 (in_data),
    .dr (w_dr),
    .ok (w_ok)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // A grant in any mid-frame state aborts and restarts with this beat as p0.
  always_comb begin
    w_next  = r_state;
    w_cap0  = 1'b0;
    w_cap1  = 1'b0;
    w_cap2  = 1'b0;
    w_eval  = 1'b0;
    w_abort = 1'b0;
    if (in_grant) begin
      w_cap0  = 1'b1;
      w_abort = (r_state != IDLE);
      w_next  = S1;
    end else begin
      case (r_state)
        S1:      begin w_cap1 = 1'b1; w_next = S2;   end
        S2:      begin w_cap2 = 1'b1; w_next = S3;   end
        S3:      begin w_eval = 1'b1; w_next = IDLE; end
        default: w_next = IDLE;
      endcase
    end
  end

  assign w_err = w_abort | (w_eval & ~w_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p0      <= '0;
      r_p1      <= '0;
      r_p2      <= '0;
      d_out     <= '0;
      d_valid   <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (w_cap0) r_p0 <= in_data;
      if (w_cap1) r_p1 <= in_data;
      if (w_cap2) r_p2 <= in_data;
      if (w_eval && w_ok) d_out <= w_dr;
      d_valid   <= w_eval & w_ok;
      frame_err <= w_err;
      if (w_err && (err_cnt != {EW{1'b1}}))
        err_cnt <= err_cnt + {{(EW-1){1'b0}}, 1'b1};
    end
  end

  assign busy = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_multi_desel.sv
// ============================================================================
// Module : tb_multi_desel
// Brief  : Randomized self-checking bench for multi_desel against a queue model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_multi_desel;

  localparam int DW = 8;
  localparam int PW = 11;
  localparam int EW = 8;

  logic          clk;
  logic          rst;
  logic          in_grant;
  logic [PW-1:0] in_data;
  logic [DW-1:0] d_out;
  logic          d_valid;
  logic          frame_err;
  logic [EW-1:0] err_cnt;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: beats collected since the last grant.
  int unsigned frm[$];
  int unsigned exp_dout;
  int unsigned exp_cnt;
  bit          exp_valid;
  bit          exp_err;

  multi_desel #(.DW(DW), .PW(PW), .EW(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_grant  (in_grant),
    .in_data   (in_data),
    .d_out     (d_out),
    .d_valid   (d_valid),
    .frame_err (frame_err),
    .err_cnt   (err_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned prod(input int unsigned d, input int unsigned k);
    return (d * k) % (1 << PW);
  endfunction

  task automatic model_reset();
    frm.delete();
    exp_dout  = 0;
    exp_cnt   = 0;
    exp_valid = 0;
    exp_err   = 0;
  endtask

  task automatic model_edge(input bit g, input int unsigned data);
    int unsigned d;
    exp_valid = 0;
    exp_err   = 0;
    if (g) begin
      if (frm.size() != 0) exp_err = 1;
      frm.delete();
      frm.push_back(data);
    end else if (frm.size() != 0) begin
      frm.push_back(data);
      if (frm.size() == 4) begin
        d = frm[3] / 8;
        if ((frm[3] % 8 == 0) && frm[0] == prod(d, 3) &&
            frm[1] == prod(d, 7) && frm[2] == prod(d, 15)) begin
          exp_valid = 1;
          exp_dout  = d;
        end else begin
          exp_err = 1;
        end
        frm.delete();
      end
    end
    if (exp_err && exp_cnt < (1 << EW) - 1) exp_cnt++;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ":d_valid"}, d_valid, exp_valid);
    check_val({tag, ":frame_err"}, frame_err, exp_err);
    check_val({tag, ":d_out"}, d_out, exp_dout);
    check_val({tag, ":err_cnt"}, err_cnt, exp_cnt);
    check_val({tag, ":busy"}, busy, frm.size() != 0);
  endtask

  task automatic cycle(input bit g, input int unsigned data, input string tag);
    in_grant = g;
    in_data  = data[PW-1:0];
    @(posedge clk);
    model_edge(g, data);
    #1;
    check_outputs(tag);
  endtask

  task automatic frame4(input int unsigned b0, input int unsigned b1,
                        input int unsigned b2, input int unsigned b3, input string tag);
    cycle(1'b1, b0, tag);
    cycle(1'b0, b1, tag);
    cycle(1'b0, b2, tag);
    cycle(1'b0, b3, tag);
  endtask

  initial begin
    int unsigned d;
    int unsigned beats[4];
    int          nb;
    int          kind;

    rst      = 1'b0;
    in_grant = 1'b0;
    in_data  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b1;

    frame4(15, 35, 75, 40, "d5");
    cycle(1'b0, 0, "d5_after");
    frame4(600, 1400, 952, 1600, "d200");
    frame4(765, 1785, 1777, 2040, "d255");
    cycle(1'b0, 1234, "idle_noise");
    frame4(15, 36, 75, 40, "bad_p1");
    frame4(15, 35, 75, 41, "bad_p3");
    cycle(1'b0, 0, "gap");

    cycle(1'b1, 15, "premature");
    cycle(1'b0, 35, "premature");
    frame4(30, 70, 150, 80, "restart_d10");
    cycle(1'b0, 0, "gap");

    frame4(3, 7, 15, 8, "b2b_d1");
    frame4(6, 14, 30, 16, "b2b_d2");
    frame4(9, 21, 45, 24, "b2b_d3");
    cycle(1'b0, 0, "gap");

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      d    = $urandom_range(0, 255);
      beats[0] = prod(d, 3);
      beats[1] = prod(d, 7);
      beats[2] = prod(d, 15);
      beats[3] = prod(d, 8);
      nb = (kind == 1) ? $urandom_range(1, 3) : 4;
      if (kind == 0) begin
        int j;
        j = $urandom_range(0, 3);
        beats[j] = beats[j] ^ (32'd1 << $urandom_range(0, PW - 1));
      end
      for (int b = 0; b < nb; b++) cycle(b == 0, beats[b], "rand");
      repeat ($urandom_range(0, 2)) cycle(1'b0, $urandom_range(0, 2047), "rand_idle");
    end

    cycle(1'b1, 21, "pre_rst");
    cycle(1'b0, 49, "pre_rst");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    in_grant = 1'b0;
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("in_rst");
    rst = 1'b1;
    frame4(21, 49, 105, 56, "d7");

    for (int i = 0; i < 300; i++) cycle(1'b1, 21, "sat");
    cycle(1'b0, 49, "sat_end");
    cycle(1'b0, 105, "sat_end");
    cycle(1'b0, 56, "sat_end");
    cycle(1'b0, 0, "final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
